sum_acc: RTL and testbench

- Streaming accumulator directly downstream of the 32-bit two-halves adder; consumes a burst of its sum words and produces one registered total per burst.
- Software or a sequencer issues start with a beat count; the block accepts beats over a valid/ready input, then presents the total on a valid/ready output.
- Used to reduce adder results (checksums, dot-product partials) without a CPU read per word.

---
 rtl/sum_acc.sv | 72 +++++++
 tb/tb_sum_acc.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/sum_acc.sv
// sum_acc: burst accumulator of adder sum words with a registered total; define SUM_ACC_SAT_EN for saturating totals
module sum_acc #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [CNT_W-1:0] len,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_ovf,
   output logic             busy
);
   typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;
   state_t           state_q, state_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] rem_q, rem_d;
   logic             ovf_q, ovf_d;
   logic [WIDTH:0]   sum;
   // state, running total, beats left and sticky carry registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         acc_q   <= '0;
         rem_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         rem_q   <= rem_d;
         ovf_q   <= ovf_d;
      end
   end
   // burst sequencing: start arms a burst, each accepted beat adds into the total, handshake releases it
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      rem_d   = rem_q;
      ovf_d   = ovf_q;
      sum     = {1'b0, acc_q} + {1'b0, in_data};
      case (state_q)
         IDLE: if (start) begin
            acc_d   = '0;
            ovf_d   = 1'b0;
            rem_d   = len;
            state_d = (len != '0) ? ACC : HOLD;
         end
         ACC: if (in_valid) begin
`ifdef SUM_ACC_SAT_EN
            acc_d = (sum[WIDTH] || (&acc_q)) ? '1 : sum[WIDTH-1:0];
`else
            acc_d = sum[WIDTH-1:0];
`endif
            ovf_d   = ovf_q | sum[WIDTH];
            rem_d   = rem_q - CNT_W'(1);
            state_d = (rem_q == CNT_W'(1)) ? HOLD : ACC;
         end
         HOLD: state_d = out_ready ? IDLE : HOLD;
         default: state_d = IDLE;
      endcase
   end
   assign in_ready  = (state_q == ACC);
   assign out_valid = (state_q == HOLD);
   assign out_data  = acc_q;
   assign out_ovf   = ovf_q;
   assign busy      = (state_q != IDLE);
endmodule

// File: tb/tb_sum_acc.sv
// tb_sum_acc: randomized and directed bursts checked against a burst-level sum model
module tb_sum_acc;
   localparam int WIDTH = 32;
   localparam int CNT_W = 8;
   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic [CNT_W-1:0] len = '0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] in_data = '0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [WIDTH-1:0] out_data;
   logic             out_ovf;
   logic             busy;
   int               n_cmp = 0;
   int               n_err = 0;
   logic [WIDTH-1:0] bq[$];

   sum_acc #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .len(len),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_ovf(out_ovf), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // model: phase 0 idle, 1 collecting beats, 2 total offered; total is the exact unbounded sum
   int          m_phase = 0;
   int          m_left = 0;
   longint      m_total = 0;

   function automatic logic [WIDTH-1:0] exp_data(input longint t);
`ifdef SUM_ACC_SAT_EN
      return (t >= 64'h0_FFFF_FFFF) ? 32'hFFFF_FFFF : t[WIDTH-1:0];
`else
      return t[WIDTH-1:0];
`endif
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_phase <= 0;
         m_left  <= 0;
         m_total <= 0;
      end else if (m_phase == 0) begin
         if (start) begin
            m_total <= 0;
            m_left  <= int'(len);
            m_phase <= (len != 0) ? 1 : 2;
         end
      end else if (m_phase == 1) begin
         if (in_valid) begin
            m_total <= m_total + longint'(in_data);
            m_left  <= m_left - 1;
            if (m_left == 1) m_phase <= 2;
         end
      end else if (out_ready) m_phase <= 0;
   end

   always @(negedge clk) begin
      if (rst_n) begin
         chk("in_ready", 64'(in_ready), 64'(m_phase == 1));
         chk("out_valid", 64'(out_valid), 64'(m_phase == 2));
         chk("busy", 64'(busy), 64'(m_phase != 0));
         if (m_phase != 1) begin
            chk("out_data", 64'(out_data), 64'(exp_data(m_total)));
            chk("out_ovf", 64'(out_ovf), 64'(m_total > 64'h0_FFFF_FFFF));
         end
      end
   end

   // beats come from bq; n beats of a len-beat burst, gap idle cycles before each, hold cycles of out_ready=0
   task automatic run_burst(input int ln, input int n, input int gap, input int hold, input bit poke);
      int k;
      @(negedge clk);
      start = 1'b1;
      len = CNT_W'(ln);
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < n; i++) begin
         repeat (gap) @(negedge clk);
         in_valid = 1'b1;
         in_data = bq.pop_front();
         if (poke) begin
            start = 1'b1;
            len = 8'd7;
         end
         k = 0;
         while (!in_ready && k < 50) begin
            @(negedge clk);
            k++;
         end
         if (k >= 50) chk("beat_timeout", 64'(k), 64'(0));
         @(negedge clk);
         in_valid = 1'b0;
         start = 1'b0;
      end
      if (n < ln) return;
      chk("latency1", 64'(out_valid), 64'(1));
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'($urandom_range(0, 1));
         in_data = $urandom;
         @(negedge clk);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      if (poke) start = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      start = 1'b0;
   endtask

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_data", 64'(out_data), 64'(0));
      chk("rst_valid", 64'({in_ready, out_valid, out_ovf, busy}), 64'(0));
      rst_n = 1'b1;
      @(negedge clk);
      // basic burst
      bq = '{32'd1, 32'd2, 32'd3, 32'd4};
      run_burst(4, 4, 0, 0, 1'b0);
      chk("basic_data", 64'(out_data), 64'd10);
      chk("basic_ovf", 64'(out_ovf), 64'd0);
      chk("basic_idle", 64'(busy), 64'd0);
      // stalls and backpressure
      bq = '{32'h10, 32'h20, 32'h30};
      run_burst(3, 3, 2, 5, 1'b0);
      chk("stall_data", 64'(out_data), 64'h60);
      // overflow
      bq = '{32'hFFFF_FFFF, 32'h2};
      run_burst(2, 2, 0, 1, 1'b0);
`ifdef SUM_ACC_SAT_EN
      chk("ovf_data", 64'(out_data), 64'hFFFF_FFFF);
`else
      chk("ovf_data", 64'(out_data), 64'h1);
`endif
      chk("ovf_flag", 64'(out_ovf), 64'd1);
      // empty burst
      run_burst(0, 0, 0, 2, 1'b0);
      chk("empty_data", 64'(out_data), 64'd0);
      chk("empty_ovf", 64'(out_ovf), 64'd0);
      // ignored start pulses mid-burst and in the handshake cycle
      bq = '{32'd5, 32'd9};
      run_burst(2, 2, 1, 2, 1'b1);
      chk("ign_data", 64'(out_data), 64'd14);
      chk("ign_idle", 64'(busy), 64'd0);
      // reset mid-burst
      bq = '{32'd7, 32'd8};
      run_burst(5, 2, 0, 0, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("abort_out", 64'({out_data, out_valid, out_ovf, busy, in_ready}), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;
      chk("abort_idle", 64'({out_valid, busy}), 64'(0));
      bq = '{32'd3};
      run_burst(1, 1, 0, 0, 1'b0);
      chk("after_abort", 64'(out_data), 64'd3);
      // random bursts
      for (int r = 0; r < 40; r++) begin
         int ln;
         ln = $urandom_range(0, 6);
         bq = {};
         for (int i = 0; i < ln; i++)
            bq.push_back(($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + $urandom_range(0, 15) : $urandom_range(0, 1000));
         run_burst(ln, ln, $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
